// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and the round-robin pick used by the mux arbiter and its
// priority sub-module.
package mux_arb_pkg;

   localparam int NUM_REQ = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {IDLE, LOCK} arb_state_t;

   // Smallest offset after 'last' wins; iterating downward lets it overwrite.
   function automatic sel_t rr_pick(input logic [NUM_REQ-1:0] req, input sel_t last);
      sel_t idx;
      rr_pick = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = last + sel_t'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side and downstream-side signals of the shared output channel.
// Handshake: a beat moves on out_data_o in any cycle where out_valid_o && out_ready_i.
interface mux_rr_arbiter_if
   import mux_arb_pkg::*;
#(
   parameter int DATA_W = 4
) ();

   logic [NUM_REQ-1:0] req_i;
   logic [DATA_W-1:0]  data_i [NUM_REQ];
   logic [NUM_REQ-1:0] gnt_o;
   sel_t               sel_o;
   logic               busy_o;
   logic               out_valid_o;
   logic [DATA_W-1:0]  out_data_o;
   logic               out_ready_i;

   modport slave (
      input  req_i, data_i, out_ready_i,
      output gnt_o, sel_o, busy_o, out_valid_o, out_data_o
   );

   modport master (
      output req_i, data_i, out_ready_i,
      input  gnt_o, sel_o, busy_o, out_valid_o, out_data_o
   );

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin winner select, starting the scan just after 'last'.
module rr_priority_pick
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  sel_t               last,
   output sel_t               winner,
   output logic               found
);

   assign winner = rr_pick(req, last);
   assign found  = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection with bounded bursts feeding one registered
// valid/ready output beat.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter int MAX_BURST = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   mux_rr_arbiter_if.slave    bus,
   output arb_state_t         dbg_state_o,
   output logic [3:0]         dbg_beat_cnt_o,
   output sel_t               dbg_last_o
);

   localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

   arb_state_t         state_q;
   sel_t               sel_q;
   sel_t               last_q;
   logic [3:0]         cnt_q;
   logic [3:0]         cnt_nxt;
   logic               valid_q;
   logic [DATA_W-1:0]  data_q;

   sel_t               winner;
   logic               any_req;
   logic               free;
   logic               load;
   sel_t               owner;

   rr_priority_pick u_pick (
      .req    (bus.req_i),
      .last   (last_q),
      .winner (winner),
      .found  (any_req)
   );

   assign free    = !valid_q || bus.out_ready_i;
   assign cnt_nxt = cnt_q + 4'd1;

   always_comb begin
      load  = 1'b0;
      owner = sel_q;
      if (state_q == IDLE) begin
         if (free && any_req) begin
            load  = 1'b1;
            owner = winner;
         end
      end else if (bus.req_i[sel_q] && free) begin
         load = 1'b1;
      end
   end

   // gnt is combinational, so it must be masked while the flops sit in reset.
   assign bus.gnt_o = (rst_n && load) ? (4'b0001 << owner) : 4'b0000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         last_q  <= 2'd3;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         if (load) begin
            data_q  <= bus.data_i[owner];
            valid_q <= 1'b1;
         end else if (bus.out_ready_i) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (load) begin
                  sel_q <= owner;
                  cnt_q <= 4'd1;
                  if (MAX_BURST == 1) last_q  <= owner;
                  else                state_q <= LOCK;
               end
            end
            LOCK: begin
               // Owner release costs one bubble; non-owner requests wait.
               if (!bus.req_i[sel_q]) begin
                  last_q  <= sel_q;
                  state_q <= IDLE;
               end else if (load) begin
                  cnt_q <= cnt_nxt;
                  if (cnt_nxt == BURST_LIM) begin
                     last_q  <= sel_q;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.sel_o       = sel_q;
   assign bus.busy_o      = (state_q == LOCK);
   assign bus.out_valid_o = valid_q;
   assign bus.out_data_o  = data_q;

   assign dbg_state_o    = state_q;
   assign dbg_beat_cnt_o = cnt_q;
   assign dbg_last_o     = last_q;

endmodule
